chan_packet_fir_coeff_loader: RTL and testbench

CHAN_PACKET_FIR_COEFF_LOADER -- requirements
Module: chan_packet_fir_coeff_loader

---
 rtl/chan_packet_fir_coeff_loader.sv | 168 ++++++++++++++++
 tb/tb_chan_packet_fir_coeff_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_packet_fir_coeff_loader.sv
// chan_packet_fir_coeff_loader
//
// Turns writes to a software load-coefficient register into single-cycle
// writes to the shadow bank of a double-buffered FIR coefficient RAM. A commit
// makes the shadow bank the active one at the next FIR frame boundary, but only
// once every tap of the shadow bank has been written.
//
// Register fields in reg_data:
//   [31] wr_toggle (any change = write), [30] commit (rising edge),
//   [29] clr_err (rising edge), [28:16] tap address, [15:0] coefficient.
//
// Ports:
//   user_clk      sole clock, rising edge
//   user_rst      synchronous active-high reset
//   reg_data      load-coefficient register value (user_clk domain)
//   fir_sync      one-cycle FIR frame-boundary pulse
//   coeff_we      coefficient RAM write-enable pulse
//   coeff_bank    bank being written (always the shadow bank)
//   coeff_addr    tap address
//   coeff_data    coefficient value
//   active_bank   bank the FIR currently reads
//   swap_pending  commit accepted, waiting for fir_sync
//   status        {err_incomplete, err_range, swap_pending, active_bank,
//                  err_busy, 11'b0, write_count}
module chan_packet_fir_coeff_loader #(
  parameter int unsigned NTAPS   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned COEFF_W = 16
) (
  input  logic               user_clk,
  input  logic               user_rst,
  input  logic [31:0]        reg_data,
  input  logic               fir_sync,
  output logic               coeff_we,
  output logic               coeff_bank,
  output logic [ADDR_W-1:0]  coeff_addr,
  output logic [COEFF_W-1:0] coeff_data,
  output logic               active_bank,
  output logic               swap_pending,
  output logic [31:0]        status
);

  typedef enum logic [0:0] {StIdle, StWaitSync} state_e;

  localparam logic [12:0] NTapsW = 13'(NTAPS);

  state_e             state_q, state_d;
  logic [2:0]         prev_q;
  logic [NTAPS-1:0]   mask_q, mask_d;
  logic [15:0]        count_q, count_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COEFF_W-1:0] data_q, data_d;
  logic               active_q, active_d;
  logic               err_inc_q, err_inc_d;
  logic               err_rng_q, err_rng_d;
  logic               err_busy_q, err_busy_d;

  logic               wr_ev, commit_ev, clr_ev;
  logic [12:0]        tap_addr;
  logic               addr_ok;
  logic [NTAPS-1:0]   wr_mask;
  logic               new_inc, new_rng, new_busy;

  // Edge detection against the previous sample of the control bits.
  assign wr_ev     = reg_data[31] ^ prev_q[2];
  assign commit_ev = reg_data[30] & ~prev_q[1];
  assign clr_ev    = reg_data[29] & ~prev_q[0];
  assign tap_addr  = reg_data[28:16];
  assign addr_ok   = tap_addr < NTapsW;

  always_comb begin
    wr_mask = '0;
    if (addr_ok) begin
      wr_mask[tap_addr[ADDR_W-1:0]] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    count_d  = count_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    active_d = active_q;
    new_inc  = 1'b0;
    new_rng  = 1'b0;
    new_busy = 1'b0;

    case (state_q)
      StIdle: begin
        if (wr_ev) begin
          if (addr_ok) begin
            we_d    = 1'b1;
            addr_d  = tap_addr[ADDR_W-1:0];
            data_d  = reg_data[COEFF_W-1:0];
            mask_d  = mask_q | wr_mask;
            count_d = count_q + 16'd1;
          end else begin
            new_rng = 1'b1;
          end
        end
        // mask_d already includes a write landing in this same cycle.
        if (commit_ev) begin
          if (&mask_d) begin
            state_d = StWaitSync;
          end else begin
            new_inc = 1'b1;
          end
        end
      end
      StWaitSync: begin
        if (wr_ev) begin
          new_busy = 1'b1;
        end
        if (fir_sync) begin
          active_d = ~active_q;
          mask_d   = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A clear loses against an error raised in the same cycle.
  assign err_inc_d  = (err_inc_q & ~clr_ev) | new_inc;
  assign err_rng_d  = (err_rng_q & ~clr_ev) | new_rng;
  assign err_busy_d = (err_busy_q & ~clr_ev) | new_busy;

  always_ff @(posedge user_clk) begin
    // Previous bits track reg_data even in reset so release fires no event.
    prev_q <= reg_data[31:29];
    if (user_rst) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      active_q   <= 1'b0;
      err_inc_q  <= 1'b0;
      err_rng_q  <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      active_q   <= active_d;
      err_inc_q  <= err_inc_d;
      err_rng_q  <= err_rng_d;
      err_busy_q <= err_busy_d;
    end
  end

  assign coeff_we     = we_q;
  assign coeff_addr   = addr_q;
  assign coeff_data   = data_q;
  assign active_bank  = active_q;
  assign coeff_bank   = ~active_q;
  assign swap_pending = (state_q == StWaitSync);
  assign status       = {err_inc_q, err_rng_q, swap_pending, active_q, err_busy_q, 11'd0, count_q};

endmodule

// File: tb/tb_chan_packet_fir_coeff_loader.sv
// Bench for chan_packet_fir_coeff_loader: directed scenarios plus a random run,
// all checked against a behavioural model of the register protocol.
module tb_chan_packet_fir_coeff_loader;

  localparam int NTAPS = 32;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic [31:0] reg_data = 32'd0;
  logic        fir_sync = 1'b0;
  logic        coeff_we, coeff_bank, active_bank, swap_pending;
  logic [4:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic [31:0] status;

  chan_packet_fir_coeff_loader #(
    .NTAPS  (32),
    .ADDR_W (5),
    .COEFF_W(16)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .reg_data    (reg_data),
    .fir_sync    (fir_sync),
    .coeff_we    (coeff_we),
    .coeff_bank  (coeff_bank),
    .coeff_addr  (coeff_addr),
    .coeff_data  (coeff_data),
    .active_bank (active_bank),
    .swap_pending(swap_pending),
    .status      (status)
  );

  always #5 user_clk = ~user_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model
  logic [2:0]  m_prev;
  bit          m_pend, m_active, m_we, m_ei, m_er, m_eb;
  bit          m_mask[NTAPS];
  int          m_count, m_addr, m_data;
  logic [31:0] rd_cur;

  logic [56:0] dut_outs;
  assign dut_outs = {coeff_we, coeff_bank, coeff_addr, coeff_data, active_bank, swap_pending,
                     status};

  function automatic logic [31:0] exp_status();
    return {m_ei, m_er, m_pend, m_active, m_eb, 11'd0, 16'(m_count)};
  endfunction

  function automatic logic [56:0] exp_outs();
    return {m_we, ~m_active, 5'(m_addr), 16'(m_data), m_active, m_pend, exp_status()};
  endfunction

  task automatic model_reset(input logic [31:0] rd);
    m_prev = rd[31:29];
    m_pend = 0; m_active = 0; m_we = 0; m_ei = 0; m_er = 0; m_eb = 0;
    m_count = 0; m_addr = 0; m_data = 0;
    foreach (m_mask[i]) m_mask[i] = 0;
  endtask

  // Advance model and DUT by one clock with the given inputs.
  task automatic cycle(input logic [31:0] rd, input logic sync);
    bit wr, cm, cl, pend_old, full, ne_i, ne_r, ne_b;
    int a;
    wr = rd[31] != m_prev[2];
    cm = rd[30] && !m_prev[1];
    cl = rd[29] && !m_prev[0];
    pend_old = m_pend;
    m_we = 0; ne_i = 0; ne_r = 0; ne_b = 0;
    a = int'(rd[28:16]);
    if (wr) begin
      if (pend_old) ne_b = 1;
      else if (a >= NTAPS) ne_r = 1;
      else begin
        m_we = 1; m_addr = a; m_data = int'(rd[15:0]); m_mask[a] = 1;
        m_count = (m_count + 1) % 65536;
      end
    end
    if (!pend_old && cm) begin
      full = 1;
      foreach (m_mask[i]) if (!m_mask[i]) full = 0;
      if (full) m_pend = 1;
      else ne_i = 1;
    end else if (pend_old && sync) begin
      m_active = !m_active;
      m_pend = 0;
      foreach (m_mask[i]) m_mask[i] = 0;
    end
    if (cl) begin m_ei = 0; m_er = 0; m_eb = 0; end
    m_ei = m_ei | ne_i; m_er = m_er | ne_r; m_eb = m_eb | ne_b;
    m_prev = rd[31:29];
    rd_cur = rd;
    reg_data = rd;
    fir_sync = sync;
    @(posedge user_clk);
    #1;
  endtask

  task automatic apply_reset(input logic [31:0] rd, input int ncyc);
    user_rst = 1'b1;
    reg_data = rd;
    fir_sync = 1'b0;
    repeat (ncyc) @(posedge user_clk);
    #1;
    model_reset(rd);
    rd_cur = rd;
    user_rst = 1'b0;
  endtask

  task automatic write_tap(input int addr, input int coeff);
    cycle({~rd_cur[31], rd_cur[30:29], 13'(addr), 16'(coeff)}, 1'b0);
  endtask

  task automatic test_reset();
    apply_reset(32'h0, 3);
    n_vec++;
    if (dut_outs !== {1'b0, 1'b1, 5'd0, 16'd0, 1'b0, 1'b0, 32'd0}) begin
      n_bad++; $display("FAIL reset_values got %h want %h", dut_outs,
                        {1'b0, 1'b1, 5'd0, 16'd0, 1'b0, 1'b0, 32'd0});
    end
  endtask

  task automatic test_load_all();
    for (int a = 0; a < NTAPS; a++) begin
      write_tap(a, a * 3);
      n_vec++;
      if ({coeff_we, coeff_bank, coeff_addr, coeff_data} !== {1'b1, 1'b1, 5'(a), 16'(a * 3)})
      begin
        n_bad++; $display("FAIL load_pulse a=%0d got we=%b bank=%b addr=%0d data=%0d want 1 1 %0d %0d",
                          a, coeff_we, coeff_bank, coeff_addr, coeff_data, a, a * 3);
      end
      cycle(rd_cur, 1'b0);
      n_vec++;
      if (coeff_we !== 1'b0 || dut_outs !== exp_outs()) begin
        n_bad++; $display("FAIL load_gap a=%0d got %h want %h", a, dut_outs, exp_outs());
      end
    end
    n_vec++;
    if (status[15:0] !== 16'd32) begin
      n_bad++; $display("FAIL load_count got %0d want 32", status[15:0]);
    end
  endtask

  task automatic test_commit_swap();
    cycle({rd_cur[31], 1'b1, rd_cur[29:0]}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({swap_pending, active_bank, coeff_bank} !== 3'b101) begin
        n_bad++; $display("FAIL swap_wait i=%0d got %b want 101", i,
                          {swap_pending, active_bank, coeff_bank});
      end
      cycle(rd_cur, 1'b0);
    end
    cycle(rd_cur, 1'b1);
    n_vec++;
    if ({swap_pending, active_bank, coeff_bank} !== 3'b010 || dut_outs !== exp_outs()) begin
      n_bad++; $display("FAIL swap_done got %h want %h", dut_outs, exp_outs());
    end
    // Mask must be empty now: a fresh commit is rejected as incomplete.
    cycle({rd_cur[31], 1'b0, rd_cur[29:0]}, 1'b0);
    cycle({rd_cur[31], 1'b1, rd_cur[29:0]}, 1'b0);
    n_vec++;
    if ({status[31], swap_pending} !== 2'b10) begin
      n_bad++; $display("FAIL mask_cleared got inc=%b pend=%b want 1 0", status[31], swap_pending);
    end
    cycle({rd_cur[31], 1'b0, 1'b1, rd_cur[28:0]}, 1'b0);
    cycle({rd_cur[31], 2'b00, rd_cur[28:0]}, 1'b0);
  endtask

  task automatic test_incomplete();
    for (int a = 0; a < NTAPS - 1; a++) write_tap(a, 16'h100 + a);
    cycle({rd_cur[31], 1'b1, rd_cur[29:0]}, 1'b0);
    n_vec++;
    if ({status[31], swap_pending} !== 2'b10 || dut_outs !== exp_outs()) begin
      n_bad++; $display("FAIL incomplete got %h want %h", dut_outs, exp_outs());
    end
    cycle({rd_cur[31], 1'b0, rd_cur[29:0]}, 1'b0);
    cycle({rd_cur[31:30], 1'b1, rd_cur[28:0]}, 1'b0);
    n_vec++;
    if (status[31] !== 1'b0) begin
      n_bad++; $display("FAIL clr_err got status31=%b want 0", status[31]);
    end
    cycle({rd_cur[31:30], 1'b0, rd_cur[28:0]}, 1'b0);
  endtask

  task automatic test_same_cycle();
    cycle({~rd_cur[31], 2'b10, 13'd31, 16'h1234}, 1'b0);
    n_vec++;
    if ({coeff_we, coeff_addr, coeff_data, swap_pending} !== {1'b1, 5'd31, 16'h1234, 1'b1}) begin
      n_bad++; $display("FAIL same_cycle got we=%b addr=%0d data=%h pend=%b want 1 31 1234 1",
                        coeff_we, coeff_addr, coeff_data, swap_pending);
    end
  endtask

  task automatic test_range_busy();
    logic [15:0] cnt;
    cnt = status[15:0];
    write_tap(5, 16'hBEEF);
    n_vec++;
    if ({coeff_we, status[27], status[15:0]} !== {1'b0, 1'b1, cnt}) begin
      n_bad++; $display("FAIL busy_drop got we=%b busy=%b cnt=%0d want 0 1 %0d",
                        coeff_we, status[27], status[15:0], cnt);
    end
    cycle(rd_cur, 1'b1);
    cycle({rd_cur[31], 1'b0, rd_cur[29:0]}, 1'b0);
    write_tap(40, 16'h5555);
    n_vec++;
    if ({coeff_we, status[30], status[15:0]} !== {1'b0, 1'b1, cnt} || dut_outs !== exp_outs())
    begin
      n_bad++; $display("FAIL range got we=%b rng=%b cnt=%0d want 0 1 %0d",
                        coeff_we, status[30], status[15:0], cnt);
    end
    cycle({rd_cur[31:30], 1'b1, rd_cur[28:0]}, 1'b0);
    cycle({rd_cur[31:30], 1'b0, rd_cur[28:0]}, 1'b0);
    n_vec++;
    if (status[31:27] !== {3'b000, m_active, 1'b0}) begin
      n_bad++; $display("FAIL err_clear got %b want 000%b0", status[31:27], m_active);
    end
  endtask

  task automatic test_reset_in_wait();
    for (int a = 0; a < NTAPS; a++) write_tap(a, a);
    if (rd_cur[31] == 1'b0) write_tap(0, 7);
    cycle({rd_cur[31], 1'b1, rd_cur[29:0]}, 1'b0);
    n_vec++;
    if (swap_pending !== 1'b1) begin
      n_bad++; $display("FAIL rst_wait_entry got pend=%b want 1", swap_pending);
    end
    apply_reset(rd_cur, 2);
    n_vec++;
    if (dut_outs !== {1'b0, 1'b1, 5'd0, 16'd0, 1'b0, 1'b0, 32'd0}) begin
      n_bad++; $display("FAIL rst_wait_values got %h want %h", dut_outs,
                        {1'b0, 1'b1, 5'd0, 16'd0, 1'b0, 1'b0, 32'd0});
    end
    for (int i = 0; i < 3; i++) begin
      cycle(rd_cur, 1'b0);
      n_vec++;
      if (coeff_we !== 1'b0 || active_bank !== 1'b0 || dut_outs !== exp_outs()) begin
        n_bad++; $display("FAIL rst_release i=%0d got %h want %h", i, dut_outs, exp_outs());
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic        sync;
    for (int i = 0; i < 600; i++) begin
      rd = rd_cur;
      if ($urandom_range(0, 9) < 4) begin
        rd[31]    = ~rd[31];
        rd[28:16] = 13'($urandom_range(0, 39));
        rd[15:0]  = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) rd[30] = ~rd[30];
      if ($urandom_range(0, 11) == 0) rd[29] = ~rd[29];
      sync = ($urandom_range(0, 5) == 0);
      cycle(rd, sync);
      n_vec++;
      if (dut_outs !== exp_outs()) begin
        n_bad++; $display("FAIL random i=%0d got %h want %h", i, dut_outs, exp_outs());
      end
    end
  endtask

  initial begin
    model_reset(32'h0);
    rd_cur = 32'h0;
    test_reset();
    test_load_all();
    test_commit_swap();
    test_incomplete();
    test_same_cycle();
    test_range_busy();
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
